// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one combinational full adder plus a registered carry, LSB first.
// Latency: done pulses in the cycle after edge E0+WIDTH; WIDTH+1 cycles per add back-to-back, WIDTH+2 via IDLE.
// Backpressure: none; start is only honoured in IDLE or DONE and is ignored while busy.

module full_adder (
    output logic fsum,
    output logic fcarry,
    input  logic a,
    input  logic b,
    input  logic c
);
    assign fsum   = a ^ b ^ c;
    assign fcarry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fsum;
    logic             fcarry;
    logic             accept_d;
    logic             last_d;

    full_adder u_fa (
        .fsum   (fsum),
        .fcarry (fcarry),
        .a      (a_q[0]),
        .b      (b_q[0]),
        .c      (carry_q)
    );

    // Next result-shift value, final-bit detect and start acceptance.
    always_comb begin
        res_d    = {fsum, res_q[WIDTH-1:1]};
        last_d   = (cnt_q == CW'(WIDTH - 1));
        accept_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Control FSM and datapath: load on accepted start, shift one bit per RUN cycle,
    // commit sum/cout only on the RUN->DONE edge so outputs stay stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_d) begin
                a_q     <= a_in;
                b_q     <= b_in;
                carry_q <= cin;
                cnt_q   <= '0;
                res_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= S_RUN;
            end else begin
                case (state_q)
                    S_RUN: begin
                        a_q     <= a_q >> 1;
                        b_q     <= b_q >> 1;
                        res_q   <= res_d;
                        carry_q <= fcarry;
                        if (last_d) begin
                            sum_q   <= res_d;
                            cout_q  <= fcarry;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit instance for functional/timing cases,
// 2-bit instance swept over every operand/carry combination.
// Samples outputs 1 time unit after the rising edge; drives inputs away from edges.

module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       s2_start;
    logic [1:0] s2_a;
    logic [1:0] s2_b;
    logic       s2_cin;
    logic       s2_busy;
    logic       s2_done;
    logic [1:0] s2_sum;
    logic       s2_cout;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s2_start),
        .a_in  (s2_a),
        .b_in  (s2_b),
        .cin   (s2_cin),
        .busy  (s2_busy),
        .done  (s2_done),
        .sum   (s2_sum),
        .cout  (s2_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one add on the 8-bit instance and wait (bounded) for done.
    // lat = posedges after the start edge until done is seen, -1 on timeout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output int bcnt);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = ~a; b_in = 8'hC3; cin = ~c;
        lat = -1; bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_cin = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_op(8'h5A, 8'h3C, 1'b0, lat, bcnt);
        n_cmp++;
        if ({cout, sum} !== 9'h096) begin
            n_err++;
            $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=96", cout, sum);
        end
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles, want 8", lat);
        end
        n_cmp++;
        if (bcnt !== 8) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy} !== 2'b00 || sum !== 8'h96) begin
            n_err++;
            $display("FAIL basic_hold: got done=%b busy=%b sum=%h, want 0 0 96", done, busy, sum);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [8:0] ve [3];
        int lat, bcnt;
        va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; ve[0] = 9'h100;
        va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1; ve[1] = 9'h1FF;
        va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b0; ve[2] = 9'h000;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], vc[k], lat, bcnt);
            n_cmp++;
            if (lat !== 8 || {cout, sum} !== ve[k]) begin
                n_err++;
                $display("FAIL vector_%0d: got lat=%0d {cout,sum}=%h, want lat=8 %h", k, lat, {cout, sum}, ve[k]);
            end
        end
    endtask

    task automatic test_start_in_run();
        int ndone;
        logic [7:0] first_sum;
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_sum = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i >= 2 && i <= 5) begin start = 1'b1; a_in = 8'h11; b_in = 8'h11; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin ndone++; first_sum = sum; end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 1) begin
            n_err++;
            $display("FAIL start_in_run_pulses: got %0d done pulses, want 1", ndone);
        end
        n_cmp++;
        if (first_sum !== 8'h96 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_run_sum: got sum=%h cout=%b, want 96 0", first_sum, cout);
        end
    endtask

    task automatic test_reset_in_run();
        int ndone, lat, bcnt;
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_in_run: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", ndone);
        end
        run_op(8'h0F, 8'h01, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 8 || {cout, sum} !== 9'h010) begin
            n_err++;
            $display("FAIL reset_then_add: got lat=%0d cout=%b sum=%h, want 8 0 10", lat, cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        int ndone, t0, t1;
        logic [8:0] r0, r1;
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a_in = 8'h80; b_in = 8'h80;
        ndone = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone == 0) begin t0 = i; r0 = {cout, sum}; end
                else if (ndone == 1) begin t1 = i; r1 = {cout, sum}; start = 1'b0; end
                ndone++;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d, want 2", ndone);
        end
        n_cmp++;
        if (r0 !== 9'h003 || t0 !== 8) begin
            n_err++;
            $display("FAIL b2b_first: got {cout,sum}=%h at %0d, want 003 at 8", r0, t0);
        end
        n_cmp++;
        if (r1 !== 9'h100) begin
            n_err++;
            $display("FAIL b2b_second: got {cout,sum}=%h, want 100", r1);
        end
        n_cmp++;
        if (t1 - t0 !== 9) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, want 9", t1 - t0);
        end
    endtask

    task automatic test_width2();
        int lat;
        logic [2:0] exp_v;
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vec;
            vec = 5'(v);
            @(negedge clk);
            s2_a = vec[4:3]; s2_b = vec[2:1]; s2_cin = vec[0]; s2_start = 1'b1;
            exp_v = 3'(vec[4:3]) + 3'(vec[2:1]) + 3'(vec[0]);
            @(posedge clk); #1;
            s2_start = 1'b0; s2_a = ~vec[4:3]; s2_b = ~vec[2:1]; s2_cin = ~vec[0];
            lat = -1;
            for (int i = 1; i <= 8; i++) begin
                @(posedge clk); #1;
                if (s2_done) begin lat = i; break; end
            end
            n_cmp++;
            if (lat !== 2 || {s2_cout, s2_sum} !== exp_v) begin
                n_err++;
                $display("FAIL w2_a%0d_b%0d_c%0d: got lat=%0d {cout,sum}=%0d, want lat=2 %0d",
                         vec[4:3], vec[2:1], vec[0], lat, {s2_cout, s2_sum}, exp_v);
            end else begin
                $display("PASS w2_a%0d_b%0d_c%0d = %0d", vec[4:3], vec[2:1], vec[0], exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_start_in_run();
        test_reset_in_run();
        test_back_to_back();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
